// File: rtl/spi_xfer_ctrl_pkg.sv
// rtl/spi_xfer_ctrl_pkg.sv - shared sizes, FSM encoding and word-count helper for the SPI transfer sequencer
package spi_xfer_ctrl_pkg;

  localparam int SPI_CHAR_LEN_BITS = 7;
  localparam int SPI_MAX_CHAR      = 128;
  localparam int SPI_DIV_W         = 16;
  localparam int SPI_SS_NB         = 8;
  localparam int SPI_WORD_W        = 32;

  typedef enum logic [2:0] {
    SPI_XC_IDLE   = 3'd0,
    SPI_XC_LOAD   = 3'd1,
    SPI_XC_SETUP  = 3'd2,
    SPI_XC_SHIFT  = 3'd3,
    SPI_XC_HOLD   = 3'd4,
    SPI_XC_UNLOAD = 3'd5
  } spi_xc_state_t;

  // Number of 32-bit words touched by a transfer; a zero length field means a full-width transfer.
  function automatic int unsigned spi_word_count(input int unsigned len_field, input int unsigned max_char);
    int unsigned bits;
    bits = (len_field == 0) ? max_char : len_field;
    return (bits + 31) >> 5;
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// rtl/spi_xfer_ctrl_if.sv - command, TX word and RX word handshakes of the SPI transfer sequencer
interface spi_xfer_ctrl_if
  import spi_xfer_ctrl_pkg::*;
#(
  parameter int CHAR_LEN_BITS = SPI_CHAR_LEN_BITS,
  parameter int DIV_W         = SPI_DIV_W,
  parameter int SS_NB         = SPI_SS_NB
);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [CHAR_LEN_BITS-1:0] cmd_len;
  logic                     cmd_lsb;
  logic                     cmd_rx_neg;
  logic                     cmd_tx_neg;
  logic [DIV_W-1:0]         cmd_div;
  logic [SS_NB-1:0]         cmd_ss;

  logic                     txw_valid;
  logic                     txw_ready;
  logic [31:0]              txw_data;

  logic                     rxw_valid;
  logic                     rxw_ready;
  logic [31:0]              rxw_data;

  modport master (
    output cmd_valid, cmd_len, cmd_lsb, cmd_rx_neg, cmd_tx_neg, cmd_div, cmd_ss,
    output txw_valid, txw_data,
    output rxw_ready,
    input  cmd_ready, txw_ready, rxw_valid, rxw_data
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_lsb, cmd_rx_neg, cmd_tx_neg, cmd_div, cmd_ss,
    input  txw_valid, txw_data,
    input  rxw_ready,
    output cmd_ready, txw_ready, rxw_valid, rxw_data
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - sclk divider with registered pos/neg edge strobes
module spi_sclk_gen
  import spi_xfer_ctrl_pkg::*;
#(
  parameter int DIV_W = SPI_DIV_W
) (
  input  logic             clk_shift,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             sclk,
  output logic             pos_edge,
  output logic             neg_edge
);

  logic [DIV_W-1:0] cnt;
  logic             phase;
  logic             tc;

  // phase is the level sclk will take one cycle after each strobe, so a strobe always leads its sclk transition.
  assign tc = en && (cnt == div);

  // Divider, phase and strobes; everything collapses to idle-low whenever the generator is disabled.
  always_ff @(posedge clk_shift) begin
    if (rst || !en) begin
      cnt      <= '0;
      phase    <= 1'b0;
      sclk     <= 1'b0;
      pos_edge <= 1'b0;
      neg_edge <= 1'b0;
    end else begin
      cnt      <= tc ? '0 : cnt + DIV_W'(1);
      phase    <= phase ^ tc;
      pos_edge <= tc && !phase;
      neg_edge <= tc && phase;
      sclk     <= phase;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - sequencer that loads, runs and unloads one spi_shift transfer at a time
module spi_xfer_ctrl
  import spi_xfer_ctrl_pkg::*;
#(
  parameter int CHAR_LEN_BITS = SPI_CHAR_LEN_BITS,
  parameter int MAX_CHAR      = SPI_MAX_CHAR,
  parameter int DIV_W         = SPI_DIV_W,
  parameter int SS_NB         = SPI_SS_NB
) (
  input  logic                     clk_shift,
  input  logic                     rst,
  spi_xfer_ctrl_if.slave           bus,
  output logic                     busy,
  output logic [3:0]               latch,
  output logic [3:0]               byte_sel,
  output logic [31:0]              p_in,
  output logic [CHAR_LEN_BITS-1:0] len,
  output logic                     lsb,
  output logic                     rx_negedge,
  output logic                     tx_negedge,
  output logic                     go,
  output logic                     pos_edge,
  output logic                     neg_edge,
  output logic                     s_clk,
  input  logic                     tip,
  input  logic                     last,
  input  logic [MAX_CHAR-1:0]      p_out,
  output logic                     sclk_pad_o,
  output logic [SS_NB-1:0]         ss_pad_o
);

  localparam int WORDS = MAX_CHAR / SPI_WORD_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  spi_xc_state_t    state;
  spi_xc_state_t    state_next;

  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] last_idx;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] wcnt;
  logic [SS_NB-1:0] ss_r;
  logic             tip_seen;

  logic             cmd_fire;
  logic             txw_fire;
  logic             rxw_fire;
  logic             tip_fall;
  logic             gen_en;
  logic             sclk;

  logic             load_word;
  logic             go_set;
  logic             ss_assert;
  logic             ss_release;
  logic             wcnt_inc;
  logic             widx_inc;

  // spi_shift reports its last bit through tip alone; the last strobe is not needed here.
  logic             unused_last;
  assign unused_last = last;

  assign bus.cmd_ready = (state == SPI_XC_IDLE);
  // Never overwrite the shift register while a transfer is still in progress.
  assign bus.txw_ready = (state == SPI_XC_LOAD) && !tip;
  assign bus.rxw_valid = (state == SPI_XC_UNLOAD);
  assign bus.rxw_data  = p_out[{widx, 5'b00000} +: 32];

  assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
  assign txw_fire = bus.txw_valid && bus.txw_ready;
  assign rxw_fire = bus.rxw_valid && bus.rxw_ready;

  assign busy     = (state != SPI_XC_IDLE);
  assign tip_fall = (state == SPI_XC_SHIFT) && tip_seen && !tip;
  // Edges only run while spi_shift is actually shifting.
  assign gen_en   = (state == SPI_XC_SHIFT) && tip;

  assign s_clk      = sclk;
  assign sclk_pad_o = sclk;

  spi_sclk_gen #(
    .DIV_W (DIV_W)
  ) u_sclk_gen (
    .clk_shift (clk_shift),
    .rst       (rst),
    .en        (gen_en),
    .div       (div_r),
    .sclk      (sclk),
    .pos_edge  (pos_edge),
    .neg_edge  (neg_edge)
  );

  // State register.
  always_ff @(posedge clk_shift) begin
    if (rst) begin
      state <= SPI_XC_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and one-cycle control strobes for the datapath.
  always_comb begin
    state_next = state;
    load_word  = 1'b0;
    go_set     = 1'b0;
    ss_assert  = 1'b0;
    ss_release = 1'b0;
    wcnt_inc   = 1'b0;
    widx_inc   = 1'b0;
    unique case (state)
      SPI_XC_IDLE: begin
        if (cmd_fire) begin
          state_next = SPI_XC_LOAD;
        end
      end
      SPI_XC_LOAD: begin
        if (txw_fire) begin
          load_word = 1'b1;
          widx_inc  = 1'b1;
          if (widx == last_idx) begin
            state_next = SPI_XC_SETUP;
            ss_assert  = 1'b1;
          end
        end
      end
      SPI_XC_SETUP: begin
        if (wcnt == div_r) begin
          go_set     = 1'b1;
          state_next = SPI_XC_SHIFT;
        end else begin
          wcnt_inc = 1'b1;
        end
      end
      SPI_XC_SHIFT: begin
        if (tip_fall) begin
          state_next = SPI_XC_HOLD;
        end
      end
      SPI_XC_HOLD: begin
        if (wcnt == div_r) begin
          ss_release = 1'b1;
          state_next = SPI_XC_UNLOAD;
        end else begin
          wcnt_inc = 1'b1;
        end
      end
      SPI_XC_UNLOAD: begin
        if (rxw_fire) begin
          widx_inc = 1'b1;
          if (widx == last_idx) begin
            state_next = SPI_XC_IDLE;
          end
        end
      end
      default: begin
        state_next = SPI_XC_IDLE;
      end
    endcase
  end

  // Word index and wait counter restart on every state change so LOAD and UNLOAD both begin at word 0.
  always_ff @(posedge clk_shift) begin
    if (rst) begin
      widx <= '0;
      wcnt <= '0;
    end else begin
      if (state_next != state) begin
        widx <= '0;
      end else if (widx_inc) begin
        widx <= widx + IDX_W'(1);
      end
      wcnt <= wcnt_inc ? wcnt + DIV_W'(1) : '0;
    end
  end

  // Transfer configuration is captured once per command and held until the next one.
  always_ff @(posedge clk_shift) begin
    if (rst) begin
      len        <= '0;
      lsb        <= 1'b0;
      rx_negedge <= 1'b0;
      tx_negedge <= 1'b0;
      div_r      <= '0;
      ss_r       <= '0;
      last_idx   <= '0;
    end else if (cmd_fire) begin
      len        <= bus.cmd_len;
      lsb        <= bus.cmd_lsb;
      rx_negedge <= bus.cmd_rx_neg;
      tx_negedge <= bus.cmd_tx_neg;
      div_r      <= bus.cmd_div;
      ss_r       <= bus.cmd_ss;
      last_idx   <= IDX_W'(spi_word_count(32'(bus.cmd_len), MAX_CHAR) - 1);
    end
  end

  // One-cycle load and go pulses towards spi_shift, slave-select pins, and tip tracking.
  always_ff @(posedge clk_shift) begin
    if (rst) begin
      latch    <= '0;
      byte_sel <= '0;
      p_in     <= '0;
      go       <= 1'b0;
      ss_pad_o <= '1;
      tip_seen <= 1'b0;
    end else begin
      latch    <= load_word ? 4'(4'b0001 << widx) : 4'b0000;
      byte_sel <= load_word ? 4'hF : 4'h0;
      p_in     <= load_word ? bus.txw_data : 32'h0;
      go       <= go_set;
      if (ss_assert) begin
        ss_pad_o <= ~ss_r;
      end else if (ss_release) begin
        ss_pad_o <= '1;
      end
      if (go_set || (state != SPI_XC_SHIFT)) begin
        tip_seen <= 1'b0;
      end else if (tip) begin
        tip_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - directed self-checking bench for spi_xfer_ctrl with a looped-back spi_shift model
module tb_spi_xfer_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_ctrl_if #(.CHAR_LEN_BITS(7), .DIV_W(16), .SS_NB(8)) bus ();

  logic         busy;
  logic [3:0]   latch;
  logic [3:0]   byte_sel;
  logic [31:0]  p_in;
  logic [6:0]   len;
  logic         lsb;
  logic         rx_negedge;
  logic         tx_negedge;
  logic         go;
  logic         pos_edge;
  logic         neg_edge;
  logic         s_clk;
  logic         sclk_pad_o;
  logic [7:0]   ss_pad_o;

  logic [127:0] mdata = '0;
  int           mcnt  = 0;
  logic         mtip  = 1'b0;
  logic         mlast;
  int           mbits;

  spi_xfer_ctrl #(
    .CHAR_LEN_BITS (7),
    .MAX_CHAR      (128),
    .DIV_W         (16),
    .SS_NB         (8)
  ) dut (
    .clk_shift  (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .latch      (latch),
    .byte_sel   (byte_sel),
    .p_in       (p_in),
    .len        (len),
    .lsb        (lsb),
    .rx_negedge (rx_negedge),
    .tx_negedge (tx_negedge),
    .go         (go),
    .pos_edge   (pos_edge),
    .neg_edge   (neg_edge),
    .s_clk      (s_clk),
    .tip        (mtip),
    .last       (mlast),
    .p_out      (mdata),
    .sclk_pad_o (sclk_pad_o),
    .ss_pad_o   (ss_pad_o)
  );

  // spi_shift model with s_out looped to s_in: each sample strobe rotates the active field by one bit.
  function automatic logic [127:0] rot(input logic [127:0] d, input int bits, input logic lsb_first);
    logic [127:0] r;
    r = d;
    if (lsb_first) begin
      for (int i = 0; i < bits - 1; i++) r[i] = d[i+1];
      r[bits-1] = d[0];
    end else begin
      for (int i = bits - 1; i > 0; i--) r[i] = d[i-1];
      r[0] = d[bits-1];
    end
    return r;
  endfunction

  assign mbits = (len == 7'd0) ? 128 : int'(len);
  assign mlast = mtip && (mcnt == mbits - 1);

  always @(posedge clk) begin
    if (rst) begin
      mtip <= 1'b0;
      mcnt <= 0;
    end else begin
      for (int w = 0; w < 4; w++)
        for (int b = 0; b < 4; b++)
          if (latch[w] && byte_sel[b]) mdata[32*w+8*b +: 8] <= p_in[8*b +: 8];
      if (go) begin
        mtip <= 1'b1;
        mcnt <= 0;
      end else if (mtip && (rx_negedge ? neg_edge : pos_edge)) begin
        mdata <= rot(mdata, mbits, lsb);
        mcnt  <= mcnt + 1;
        if (mcnt + 1 == mbits) mtip <= 1'b0;
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  int         ncyc = 0, pos_cnt = 0, neg_cnt = 0, both_cnt = 0, go_cnt = 0, go_cyc = 0;
  int         rise_cnt = 0, fall_cnt = 0, sclk_mis = 0;
  logic [7:0] ss_at_go = '0;
  logic [6:0] len_at_go = '0;
  logic       txn_at_go = 1'b0, sclk_after_fall = 1'b0;
  logic       sclk_d = 1'b0, tip_d1 = 1'b0, tip_d2 = 1'b0;
  int         pos_cyc_q[$];
  int         str_cyc_q[$];
  bit         str_kind_q[$];
  logic [3:0] latch_q[$];
  logic [31:0] pin_q[$];

  always @(negedge clk) begin
    ncyc   <= ncyc + 1;
    sclk_d <= sclk_pad_o;
    tip_d1 <= mtip;
    tip_d2 <= tip_d1;
    if (pos_edge) begin pos_cnt <= pos_cnt + 1; pos_cyc_q.push_back(ncyc); end
    if (neg_edge) neg_cnt <= neg_cnt + 1;
    if (pos_edge && neg_edge) both_cnt <= both_cnt + 1;
    if (pos_edge || neg_edge) begin str_cyc_q.push_back(ncyc); str_kind_q.push_back(pos_edge); end
    if (sclk_pad_o && !sclk_d) rise_cnt <= rise_cnt + 1;
    if (s_clk !== sclk_pad_o) sclk_mis <= sclk_mis + 1;
    if (latch != 4'h0) begin latch_q.push_back(latch); pin_q.push_back(p_in); end
    if (go) begin
      go_cnt    <= go_cnt + 1;
      go_cyc    <= ncyc;
      ss_at_go  <= ss_pad_o;
      len_at_go <= len;
      txn_at_go <= tx_negedge;
    end
    if (tip_d2 && !tip_d1 && !mtip) begin
      fall_cnt        <= fall_cnt + 1;
      sclk_after_fall <= sclk_pad_o;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [6:0] l, input logic lsb_i, input logic rxn, input logic txn,
                          input logic [15:0] d, input logic [7:0] s);
    int n;
    @(negedge clk);
    bus.cmd_len = l; bus.cmd_lsb = lsb_i; bus.cmd_rx_neg = rxn; bus.cmd_tx_neg = txn;
    bus.cmd_div = d; bus.cmd_ss = s; bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin @(negedge clk); n++; end
    chk("cmd_ready", 32'(bus.cmd_ready), 1);
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic send_tx(input logic [31:0] w, output int acc_cyc);
    int n;
    @(negedge clk);
    bus.txw_data = w; bus.txw_valid = 1'b1;
    n = 0;
    while (!bus.txw_ready && n < 200) begin @(negedge clk); n++; end
    chk("txw_ready", 32'(bus.txw_ready), 1);
    acc_cyc = ncyc;
    @(posedge clk); #1 bus.txw_valid = 1'b0;
  endtask

  task automatic recv_rx(input logic [31:0] exp, input int stall);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.rxw_valid && n < 3000) begin @(negedge clk); n++; end
    chk("rxw_valid", 32'(bus.rxw_valid), 1);
    repeat (stall) begin
      chk("rx_stall_data", bus.rxw_data, exp);
      @(negedge clk);
    end
    chk("rx_data", bus.rxw_data, exp);
    bus.rxw_ready = 1'b1;
    @(posedge clk); #1 bus.rxw_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pbase, sbase, lbase, gbase, fbase, rbase, acc, errs, n;
    logic [31:0] words [4];

    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_lsb = 1'b0; bus.cmd_rx_neg = 1'b0;
    bus.cmd_tx_neg = 1'b0; bus.cmd_div = '0; bus.cmd_ss = '0;
    bus.txw_valid = 1'b0; bus.txw_data = '0; bus.rxw_ready = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ss", 32'(ss_pad_o), 32'hFF);
    chk("rst_sclk", 32'(sclk_pad_o), 0);
    chk("rst_go_latch", 32'({go, latch, pos_edge, neg_edge}), 0);
    chk("rst_txw_rxw", 32'({bus.txw_ready, bus.rxw_valid}), 0);

    // TX/RX handshakes offered in IDLE are ignored.
    lbase = latch_q.size();
    bus.txw_valid = 1'b1; bus.txw_data = 32'h12345678; bus.rxw_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.txw_valid = 1'b0; bus.rxw_ready = 1'b0;
    chk("idle_ignore_latch", latch_q.size() - lbase, 0);
    chk("idle_ignore_busy", 32'(busy), 0);

    // len=8, div=1, ss=01, MSB first.
    pbase = pos_cyc_q.size(); rbase = rise_cnt;
    send_cmd(7'd8, 1'b0, 1'b0, 1'b0, 16'd1, 8'h01);
    send_tx(32'h000000A5, acc);
    recv_rx(32'h000000A5, 0);
    chk("t1_ss_active", 32'(ss_at_go), 32'hFE);
    chk("t1_len_out", 32'(len_at_go), 8);
    chk("t1_pos_count", pos_cyc_q.size() - pbase, 8);
    chk("t1_sclk_rises", rise_cnt - rbase, 8);
    errs = 0;
    for (int k = pbase + 1; k < pos_cyc_q.size(); k++)
      if (pos_cyc_q[k] - pos_cyc_q[k-1] != 4) errs++;
    chk("t1_period_errs", errs, 0);
    @(negedge clk);
    chk("t1_idle_ready", 32'(bus.cmd_ready), 1);
    chk("t1_idle_ss", 32'(ss_pad_o), 32'hFF);

    // Full-width transfer: len=0 means 128 bits over 4 words.
    words[0] = 32'h11223344; words[1] = 32'h55667788; words[2] = 32'h99AABBCC; words[3] = 32'hDDEEFF00;
    pbase = pos_cyc_q.size(); lbase = latch_q.size();
    send_cmd(7'd0, 1'b0, 1'b0, 1'b0, 16'd0, 8'h04);
    for (int k = 0; k < 4; k++) send_tx(words[k], acc);
    for (int k = 0; k < 4; k++) recv_rx(words[k], 0);
    chk("t2_latch_count", latch_q.size() - lbase, 4);
    for (int k = 0; k < 4; k++) begin
      if (lbase + k < latch_q.size()) begin
        chk("t2_latch_onehot", 32'(latch_q[lbase+k]), 32'(1 << k));
        chk("t2_p_in", pin_q[lbase+k], words[k]);
      end
    end
    chk("t2_pos_count", pos_cyc_q.size() - pbase, 128);
    chk("t2_ss_active", 32'(ss_at_go), 32'hFB);

    // div=0, len=4, tx on negedge: strobes alternate every cycle.
    sbase = str_kind_q.size(); pbase = pos_cyc_q.size(); fbase = fall_cnt;
    send_cmd(7'd4, 1'b0, 1'b0, 1'b1, 16'd0, 8'h80);
    send_tx(32'h00000009, acc);
    recv_rx(32'h00000009, 0);
    chk("t3_tx_neg_out", 32'(txn_at_go), 1);
    chk("t3_pos_count", pos_cyc_q.size() - pbase, 4);
    errs = 0;
    for (int k = sbase; k < str_kind_q.size(); k++) begin
      if (str_kind_q[k] != ((k - sbase) % 2 == 0)) errs++;
      if (k > sbase && str_cyc_q[k] != str_cyc_q[k-1] + 1) errs++;
    end
    chk("t3_alt_errs", errs, 0);
    chk("t3_strobe_count", str_kind_q.size() - sbase, 8);
    chk("t3_tip_falls", fall_cnt - fbase, 1);
    chk("t3_sclk_low_after_tip", 32'(sclk_after_fall), 0);

    // Stalls: a 5-cycle gap between TX words and rxw_ready held low 10 cycles.
    gbase = go_cnt;
    send_cmd(7'd64, 1'b0, 1'b0, 1'b0, 16'd1, 8'h02);
    send_tx(32'hDEADBEEF, acc);
    repeat (5) @(negedge clk);
    chk("t4_no_go_in_gap", go_cnt - gbase, 0);
    chk("t4_txw_ready_gap", 32'(bus.txw_ready), 1);
    send_tx(32'h01234567, acc);
    recv_rx(32'hDEADBEEF, 10);
    recv_rx(32'h01234567, 0);
    chk("t4_one_go", go_cnt - gbase, 1);
    chk("t4_go_after_load", 32'(go_cyc > acc), 1);

    // Reset mid-SHIFT after 3 pos_edges, then a clean len=8 transfer.
    pbase = pos_cyc_q.size();
    send_cmd(7'd16, 1'b0, 1'b0, 1'b0, 16'd1, 8'h01);
    send_tx(32'h0000BEEF, acc);
    n = 0;
    while (pos_cyc_q.size() - pbase < 3 && n < 500) begin @(negedge clk); n++; end
    chk("t5_reached_3_pos", 32'(pos_cyc_q.size() - pbase >= 3), 1);
    chk("t5_in_shift_ss", 32'(ss_pad_o), 32'hFE);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_ss", 32'(ss_pad_o), 32'hFF);
    chk("t5_rst_sclk", 32'(sclk_pad_o), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("t5_rst_go_latch", 32'({go, latch}), 0);
    rst = 1'b0;
    pbase = pos_cyc_q.size();
    send_cmd(7'd8, 1'b0, 1'b0, 1'b0, 16'd1, 8'h01);
    send_tx(32'h0000003C, acc);
    recv_rx(32'h0000003C, 0);
    chk("t5_after_pos_count", pos_cyc_q.size() - pbase, 8);
    @(negedge clk);
    chk("t5_after_idle", 32'({bus.cmd_ready, busy}), 32'h2);

    chk("never_both_strobes", both_cnt, 0);
    chk("s_clk_matches_pad", sclk_mis, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
